quadrature_generator: RTL and testbench

Generates a two-channel quadrature pulse train (chA/chB) from a move command. The command gives a direction, an edge count and an edge period. The block is the transmitter counterpart to the quadrature direction decoder: it drives test stimulus into motor-encoder inputs and emulates an encoder for loopback/HIL tests. It sits behind the AXI/register wrapper, which issues single commands over a valid/ready handshake and reads back position and status.

---
 rtl/quadrature_generator.sv | 142 ++++++++++++++
 tb/tb_quadrature_generator.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_generator.sv
// Quadrature (A/B) pulse-train transmitter: emits a commanded number of edges
// at a fixed edge period, tracking a signed position count.
module quadrature_generator #(
   parameter int CNT_W = 16,
   parameter int PER_W = 16,
   parameter int POS_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   // Command handshake: a command transfers on a rising edge where
   // cmd_valid & cmd_ready are both high; cmd_ready depends only on state
   // and rst, and the producer must hold cmd_* stable while cmd_valid waits.
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [PER_W-1:0] cmd_period,
   input  logic             abort,
   output logic             chA,
   output logic             chB,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [POS_W-1:0] position,
   output logic             state_dbg
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic [PER_W-1:0] reload_q, reload_d;
   logic [PER_W-1:0] timer_q, timer_d;
   logic             cha_q, cha_d;
   logic             chb_q, chb_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;

   logic             accept;
   logic             toggle_a;
   logic [PER_W-1:0] cmd_reload;

   assign cmd_ready  = (state_q == S_IDLE) & ~rst;
   assign accept     = cmd_valid & cmd_ready;
   // Timer holds P-1; a zero period behaves as a period of one.
   assign cmd_reload = (cmd_period == '0) ? '0 : cmd_period - PER_W'(1);

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      steps_d   = steps_q;
      reload_d  = reload_q;
      timer_d   = timer_q;
      cha_d     = cha_q;
      chb_d     = chb_q;
      pos_d     = pos_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      // Forward advances A when A==B, else B; reverse is the mirror image.
      toggle_a  = ((cha_q == chb_q) == dir_q);

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               dir_d     = cmd_dir;
               steps_d   = cmd_steps;
               reload_d  = cmd_reload;
               timer_d   = cmd_reload;
               aborted_d = 1'b0;
               if (cmd_steps == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               // Abort takes priority over an edge due on the same clock.
               state_d   = S_IDLE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (timer_q == '0) begin
               if (toggle_a) begin
                  cha_d = ~cha_q;
               end else begin
                  chb_d = ~chb_q;
               end
               pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
               timer_d = reload_q;
               steps_d = steps_q - CNT_W'(1);
               if (steps_q == CNT_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q - PER_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dir_q     <= 1'b0;
         steps_q   <= '0;
         reload_q  <= '0;
         timer_q   <= '0;
         cha_q     <= 1'b0;
         chb_q     <= 1'b0;
         pos_q     <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         steps_q   <= steps_d;
         reload_q  <= reload_d;
         timer_q   <= timer_d;
         cha_q     <= cha_d;
         chb_q     <= chb_d;
         pos_q     <= pos_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign chA       = cha_q;
   assign chB       = chb_q;
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;
   assign aborted   = aborted_q;
   assign position  = pos_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator: expected edges and done pulses are
// queued when a command is accepted and checked as the outputs change.
module tb_quadrature_generator;

   localparam int CNT_W = 16;
   localparam int PER_W = 16;
   localparam int POS_W = 8;
   localparam int EW    = 32 + 2 + POS_W + 1;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_steps;
   logic [PER_W-1:0] cmd_period;
   logic             abort;
   logic             chA;
   logic             chB;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [POS_W-1:0] position;
   logic             state_dbg;

   quadrature_generator #(
      .CNT_W(CNT_W),
      .PER_W(PER_W),
      .POS_W(POS_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
      .cmd_period(cmd_period),
      .abort     (abort),
      .chA       (chA),
      .chB       (chB),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .position  (position),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic [32:0]   done_q[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   bit            skip_mon = 1'b1;
   logic [1:0]    prev_ab  = 2'b00;
   logic [1:0]    ab_m;
   logic [POS_W-1:0] pos_m;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic dir);
      logic [1:0] seq[4];
      int idx;
      seq = '{2'b00, 2'b10, 2'b11, 2'b01};
      idx = 0;
      for (int i = 0; i < 4; i++) if (seq[i] == ab) idx = i;
      return dir ? seq[(idx + 1) % 4] : seq[(idx + 3) % 4];
   endfunction

   // ---------------- monitor: compare edges and done pulses ----------------
   always @(posedge clk) begin
      logic [EW-1:0] e;
      logic [32:0]   d;
      #2;
      if (!skip_mon) begin
         if ({chA, chB} !== prev_ab) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL edge_unexpected: observed AB=%b at cycle %0d, expected no edge", {chA, chB}, cyc);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("edge_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
               check("edge_ab", 64'({chA, chB}), 64'(e[POS_W+2 -: 2]));
               check("edge_position", 64'(position), 64'(e[POS_W -: POS_W]));
               check("decoded_dir", 64'(chA ^ prev_ab[0]), 64'(e[0]));
            end
         end
         if (done === 1'b1) begin
            n_assert++;
            assert (done_q.size() != 0) else begin
               n_fail++;
               $error("FAIL done_unexpected: observed done=1 at cycle %0d, expected done=0", cyc);
            end
            if (done_q.size() != 0) begin
               d = done_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(d[32:1]));
               check("done_aborted", 64'(aborted), 64'(d[0]));
            end
         end
      end
      prev_ab = {chA, chB};
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic dir, input int steps, input int per,
                           input int abort_rel, output int t);
      bit rdy;
      bit accepted;
      int p;
      cmd_dir    = dir;
      cmd_steps  = CNT_W'(steps);
      cmd_period = PER_W'(per);
      cmd_valid  = 1'b1;
      accepted   = 1'b0;
      for (int k = 0; k < 2000 && !accepted; k++) begin
         rdy = cmd_ready;
         @(posedge clk);
         #1;
         if (rdy) accepted = 1'b1;
      end
      cmd_valid = 1'b0;
      t = cyc;
      if (!accepted) begin
         check("accept_timeout", 64'(0), 64'(1));
         return;
      end
      p = (per == 0) ? 1 : per;
      for (int k = 1; k <= steps; k++) begin
         if (abort_rel != 0 && k * p >= abort_rel) break;
         ab_m  = next_ab(ab_m, dir);
         pos_m = dir ? pos_m + POS_W'(1) : pos_m - POS_W'(1);
         exp_q.push_back({32'(t + k * p), ab_m, pos_m, dir});
      end
      if (abort_rel != 0 && steps != 0 && abort_rel <= steps * p)
         done_q.push_back({32'(t + abort_rel), 1'b1});
      else
         done_q.push_back({32'(t + steps * p), 1'b0});
      if (abort_rel != 0) begin
         while (cyc < t + abort_rel - 1) begin
            @(posedge clk);
            #1;
         end
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && k < 2000) begin
         @(posedge clk);
         #3;
         k++;
      end
      if (k >= 2000) check({tag, "_timeout"}, 64'(exp_q.size() + done_q.size()), 64'(0));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running, expected end of test");
      n_fail++;
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int t, ta, tb, n;
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_dir    = 1'b0;
      cmd_steps  = '0;
      cmd_period = '0;
      abort      = 1'b0;
      ab_m       = 2'b00;
      pos_m      = '0;

      // Reset state
      tick(3);
      check("rst_chA", 64'(chA), 64'(0));
      check("rst_chB", 64'(chB), 64'(0));
      check("rst_position", 64'(position), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_aborted", 64'(aborted), 64'(0));
      check("rst_cmd_ready_in_reset", 64'(cmd_ready), 64'(0));
      rst = 1'b0;
      #1;
      check("rst_cmd_ready_after", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      skip_mon = 1'b0;

      // Forward 4 edges, period 3
      send_cmd(1'b1, 4, 3, 0, t);
      check("fwd_busy", 64'(busy), 64'(1));
      check("fwd_cmd_ready", 64'(cmd_ready), 64'(0));
      wait_idle("fwd");
      check("fwd_end_busy", 64'(busy), 64'(0));
      check("fwd_end_ready", 64'(cmd_ready), 64'(1));
      check("fwd_end_position", 64'(position), 64'(4));

      // Reverse 2 edges, period 0 treated as 1
      send_cmd(1'b0, 2, 0, 0, t);
      wait_idle("rev");
      check("rev_position", 64'(position), 64'(2));
      check("rev_ab", 64'({chA, chB}), 64'(2'b11));

      // Zero-step command
      send_cmd(1'b1, 0, 5, 0, t);
      check("zero_busy", 64'(busy), 64'(0));
      wait_idle("zero");
      check("zero_done_one_cycle", 64'(done), 64'(0));
      check("zero_position", 64'(position), 64'(2));
      check("zero_ab", 64'({chA, chB}), 64'(2'b11));
      check("zero_aborted", 64'(aborted), 64'(0));

      // Abort while idle is ignored
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      tick(1);
      check("idle_abort_done", 64'(done), 64'(0));
      check("idle_abort_aborted", 64'(aborted), 64'(0));

      // Forward 10, period 2, abort coincident with the third due edge
      send_cmd(1'b1, 10, 2, 6, t);
      wait_idle("abort");
      tick(2);
      check("abort_aborted_held", 64'(aborted), 64'(1));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_position", 64'(position), 64'(pos_m));

      // Back-to-back: second command waits while busy, accepted in done cycle
      send_cmd(1'b1, 3, 2, 0, ta);
      check("b2b_busy", 64'(busy), 64'(1));
      send_cmd(1'b0, 2, 4, 0, tb);
      check("b2b_accept_cycle", 64'(tb), 64'(ta + 7));
      wait_idle("b2b");
      check("b2b_aborted_cleared", 64'(aborted), 64'(0));

      // Position wrap at the signed limit
      n = (2 ** (POS_W - 1)) - 1 - int'($signed(pos_m));
      if (n > 0) begin
         send_cmd(1'b1, n, 1, 0, t);
         wait_idle("wrap_fill");
      end
      check("wrap_at_max", 64'(position), 64'((2 ** (POS_W - 1)) - 1));
      send_cmd(1'b1, 2, 1, 0, t);
      wait_idle("wrap");
      check("wrap_position", 64'(position), 64'((2 ** (POS_W - 1)) + 1));

      // Reset during RUN
      send_cmd(1'b1, 20, 3, 0, t);
      tick(7);
      skip_mon = 1'b1;
      rst = 1'b1;
      tick(1);
      check("midrst_chA", 64'(chA), 64'(0));
      check("midrst_chB", 64'(chB), 64'(0));
      check("midrst_position", 64'(position), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      exp_q.delete();
      done_q.delete();
      ab_m  = 2'b00;
      pos_m = '0;
      rst = 1'b0;
      tick(1);
      check("midrst_done_after", 64'(done), 64'(0));
      check("midrst_ready_after", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      skip_mon = 1'b0;
      tick(10);

      // One edge after reset: phase restarts from 00
      send_cmd(1'b1, 1, 1, 0, t);
      wait_idle("post_rst");
      check("post_rst_ab", 64'({chA, chB}), 64'(2'b10));
      check("post_rst_position", 64'(position), 64'(1));

      tick(3);
      check("exp_q_empty", 64'(exp_q.size()), 64'(0));
      check("done_q_empty", 64'(done_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
